turn_game_ctrl: RTL and testbench
=================================

// Module: turn_game_ctrl
// PURPOSE
//  Parametrised N-player turn-passing game controller; successor to the fixed 6-player game.
//  Single system clock instead of a clock muxed from player buttons. Buttons are synchronised
//  and edge-detected; the current player's 3-bit move picks the next player or ends the game.
//  Adds optional wrong-turn penalty and move timeout. Sits between button/switch I/O and display.
// PARAMETERS
//  NUM_PLAYERS       6     players 1..N, legal range 2..15
//  WRONG_TURN_LOSES  1     1: out-of-turn press during play loses; 0: ignored
//  TIMEOUT_CYCLES    0     clk cycles allowed per turn; 0 disables timeout
//  START_WITH_LOSER  0     after restart: 0 -> player 1 moves first, 1 -> previous loser first
//  PW = $clog2(NUM_PLAYERS+1) (localparam, player-id width)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  player_btn   in   N        raw async button levels, bit i-1 = player i
//  player_move  in   3*N      move switches, [3i-1:3i-3] = player i
//  cur_player   out  PW       player whose turn it is (0 never driven outside reset)
//  game_over    out  1        1 while in LOSS state
//  loser        out  PW       losing player id in LOSS, else 0
//  loss_cause   out  2        00 none, 01 illegal move, 10 wrong turn, 11 timeout
//  turn_count   out  8        accepted legal moves since last start, saturates at 255
// BEHAVIOUR
//  Reset (async): PLAY, cur_player=1, game_over=0, loser=0, loss_cause=00, turn_count=0,
//   timer=0, sync/edge flops=0. Deassertion is synchronised by the surrounding reset logic.
//  Press = rising edge of player_btn[i] after 2-flop sync; state updates on 3rd rising clk edge
//   after the button level rises. player_move sampled at that same edge; must be stable 2 cycles.
//  Moves (p = current player, arithmetic mod N on 0-based index, result +1):
//   3'd1 -> p-2; 3'd2 -> p-1; 3'd4 -> p+1; 3'd5 -> p+2; 0,3,6,7 illegal -> p loses (cause 01).
//   N=2: +-2 returns to p. Legal move increments turn_count, clears timer.
//  PLAY state, per cycle priority (highest first):
//   1) WRONG_TURN_LOSES=1 and any non-current player pressed: lowest-index such player loses,
//      cause 10; a simultaneous current-player press is discarded.
//   2) current player pressed: apply move as above.
//   3) TIMEOUT_CYCLES>0 and timer==TIMEOUT_CYCLES-1: current player loses, cause 11.
//   4) else timer++ (only when TIMEOUT_CYCLES>0).
//  LOSS state: game_over=1, loser/loss_cause held, cur_player=loser. Only loser's press restarts
//   (other presses ignored): PLAY, cur_player = START_WITH_LOSER ? loser : 1, turn_count=0,
//   timer=0, loss_cause=00, loser=0. player_move ignored for the restart press.
//  Multiple presses by one player while held produce one event only (edge detect).
//  Reset mid-game or mid-press: immediate return to reset values; a button held through
//   reset release does not generate a press until released and pressed again.
// STRUCTURE
//  Package turn_game_pkg: move codes (MV_BACK2=1, MV_BACK1=2, MV_FWD1=4, MV_FWD2=5),
//   loss_cause encodings, state enum {ST_PLAY, ST_LOSS}.
//  Sub-module btn_sync_edge (parametrised width): 2-flop synchroniser + rising-edge pulse, one
//   instance of width N. Move decode and next-player wrap as combinational function in the top.
// TESTING
//  1 Reset, N=6: player1 move 4 -> cur_player=2; player2 move 1 -> cur_player=6; count=2.
//  2 Wrap: N=6, cur 6 move 5 -> cur 2; cur 1 move 2 -> cur 6; N=2 cur 1 move 5 -> cur 1.
//  3 Illegal: cur 3 move 3'd7 -> game_over=1, loser=3, cause=01; player 3 press -> cur=1,
//    game_over=0, turn_count=0 (START_WITH_LOSER=0); =1 variant -> cur=3.
//  4 Wrong turn: cur 2, players 2,4,5 press same cycle -> loser=4, cause=10; with
//    WRONG_TURN_LOSES=0 -> player2 move applied, 4,5 ignored.
//  5 Timeout: TIMEOUT_CYCLES=10, no press -> loser=cur, cause=11 exactly 10 cycles after turn
//    began; press on cycle 10 edge same cycle -> move wins.
//  6 Async reset asserted mid-LOSS and while player1 button held -> all outputs reset at once;
//    no move accepted until button released and re-pressed.

Source files
------------

// File: rtl/turn_game_pkg.sv
// Shared encodings for the turn-passing game controller.
package turn_game_pkg;

  localparam logic [2:0] MV_BACK2 = 3'd1;
  localparam logic [2:0] MV_BACK1 = 3'd2;
  localparam logic [2:0] MV_FWD1  = 3'd4;
  localparam logic [2:0] MV_FWD2  = 3'd5;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_WRONG   = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_LOSS = 1'b1
  } state_e;

  typedef struct packed {
    logic              legal;
    logic signed [2:0] delta;
  } move_dec_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge pulse for a bank of raw buttons.
// Buttons already high when reset releases stay disarmed until seen low.
module btn_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] sync1, sync2, prev, armed;
  logic [1:0]   vld_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      armed    <= '0;
      vld_pipe <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      prev     <= sync2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      // sync2 only reflects the real pin once the pipe has refilled after reset
      armed    <= armed | ({W{vld_pipe[1]}} & ~sync2);
    end
  end

  assign press = sync2 & ~prev & armed;

endmodule

// File: rtl/turn_game_ctrl.sv
// N-player turn-passing game controller: synchronised presses, move decode,
// wrong-turn / illegal-move / timeout losses and restart by the loser.
module turn_game_ctrl
  import turn_game_pkg::*;
#(
  parameter int NUM_PLAYERS      = 6,
  parameter int WRONG_TURN_LOSES = 1,
  parameter int TIMEOUT_CYCLES   = 0,
  parameter int START_WITH_LOSER = 0,
  localparam int PW = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_PLAYERS-1:0]     player_btn,
  input  logic [3*NUM_PLAYERS-1:0]   player_move,
  output logic [PW-1:0]              cur_player,
  output logic                       game_over,
  output logic [PW-1:0]              loser,
  output logic [1:0]                 loss_cause,
  output logic [7:0]                 turn_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [NUM_PLAYERS-1:0]       press;
  logic [NUM_PLAYERS-1:0][2:0]  moves;

  state_e        state_q, state_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] loser_q, loser_d;
  cause_e        cause_q, cause_d;
  logic [7:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          cur_press, loser_press, wrong_any;
  logic [2:0]    cur_mv;
  logic [PW-1:0] wrong_id;
  move_dec_t     dec;

  assign moves = player_move;

  btn_sync_edge #(.W(NUM_PLAYERS)) u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (player_btn),
    .press   (press)
  );

  function automatic move_dec_t decode_move(input logic [2:0] mv);
    move_dec_t r;
    r.legal = 1'b1;
    r.delta = 3'sd0;
    case (mv)
      MV_BACK2: r.delta = -3'sd2;
      MV_BACK1: r.delta = -3'sd1;
      MV_FWD1:  r.delta = 3'sd1;
      MV_FWD2:  r.delta = 3'sd2;
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // Wrap on the 0-based index; at most two subtractions since |delta| <= 2 <= N.
  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p,
                                                input logic signed [2:0] delta);
    int d;
    int s;
    d = delta;
    s = int'(p) - 1 + d + NUM_PLAYERS;
    if (s >= NUM_PLAYERS) s = s - NUM_PLAYERS;
    if (s >= NUM_PLAYERS) s = s - NUM_PLAYERS;
    return PW'(s + 1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PLAY;
      cur_q   <= PW'(1);
      loser_q <= '0;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      loser_q <= loser_d;
      cause_q <= cause_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    cur_press   = 1'b0;
    loser_press = 1'b0;
    cur_mv      = 3'd0;
    wrong_any   = 1'b0;
    wrong_id    = '0;
    // Descending scan so the lowest-index wrong-turn presser wins.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (PW'(i + 1) == cur_q) begin
        cur_press = press[i];
        cur_mv    = moves[i];
      end else if (press[i]) begin
        wrong_any = 1'b1;
        wrong_id  = PW'(i + 1);
      end
      if (PW'(i + 1) == loser_q) loser_press = press[i];
    end
    dec = decode_move(cur_mv);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    loser_d = loser_q;
    cause_d = cause_q;
    count_d = count_q;
    timer_d = timer_q;
    case (state_q)
      ST_PLAY: begin
        if ((WRONG_TURN_LOSES != 0) && wrong_any) begin
          state_d = ST_LOSS;
          loser_d = wrong_id;
          cur_d   = wrong_id;
          cause_d = CAUSE_WRONG;
          timer_d = '0;
        end else if (cur_press) begin
          if (dec.legal) begin
            cur_d   = next_player(cur_q, dec.delta);
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            timer_d = '0;
          end else begin
            state_d = ST_LOSS;
            loser_d = cur_q;
            cause_d = CAUSE_ILLEGAL;
            timer_d = '0;
          end
        end else if ((TIMEOUT_CYCLES > 0) && (int'(timer_q) == TIMEOUT_CYCLES - 1)) begin
          state_d = ST_LOSS;
          loser_d = cur_q;
          cause_d = CAUSE_TIMEOUT;
          timer_d = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_LOSS: begin
        if (loser_press) begin
          state_d = ST_PLAY;
          cur_d   = (START_WITH_LOSER != 0) ? loser_q : PW'(1);
          loser_d = '0;
          cause_d = CAUSE_NONE;
          count_d = '0;
          timer_d = '0;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  assign cur_player = cur_q;
  assign game_over  = (state_q == ST_LOSS);
  assign loser      = loser_q;
  assign loss_cause = cause_q;
  assign turn_count = count_q;

endmodule

// File: tb/tb_turn_game_ctrl.sv
// Directed bench: vector table on a default 6-player instance, plus hand
// sequences for timeout, no-wrong-turn, loser-restart, 2-player and reset cases.
module tb_turn_game_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0]  btn6 = '0;
  logic [17:0] mv6  = '0;
  logic [1:0]  btn2 = '0;
  logic [5:0]  mv2  = '0;

  logic [2:0] a_cur, a_loser, b_cur, b_loser;
  logic [1:0] a_cause, b_cause, c_cur, c_loser, c_cause;
  logic       a_over, b_over, c_over;
  logic [7:0] a_cnt, b_cnt, c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_game_ctrl #(.NUM_PLAYERS(6)) u_a (
    .clk(clk), .reset_n(reset_n), .player_btn(btn6), .player_move(mv6),
    .cur_player(a_cur), .game_over(a_over), .loser(a_loser),
    .loss_cause(a_cause), .turn_count(a_cnt));

  turn_game_ctrl #(.NUM_PLAYERS(6), .WRONG_TURN_LOSES(0), .TIMEOUT_CYCLES(10),
                   .START_WITH_LOSER(1)) u_b (
    .clk(clk), .reset_n(reset_n), .player_btn(btn6), .player_move(mv6),
    .cur_player(b_cur), .game_over(b_over), .loser(b_loser),
    .loss_cause(b_cause), .turn_count(b_cnt));

  turn_game_ctrl #(.NUM_PLAYERS(2)) u_c (
    .clk(clk), .reset_n(reset_n), .player_btn(btn2), .player_move(mv2),
    .cur_player(c_cur), .game_over(c_over), .loser(c_loser),
    .loss_cause(c_cause), .turn_count(c_cnt));

  typedef struct {
    int p; int mv; int cur; int over; int loser; int cause; int cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input int cur, input int over,
                         input int lsr, input int cause, input int cnt);
    chk({tag, ".cur"},   32'(a_cur),   cur);
    chk({tag, ".over"},  32'(a_over),  over);
    chk({tag, ".loser"}, 32'(a_loser), lsr);
    chk({tag, ".cause"}, 32'(a_cause), cause);
    chk({tag, ".cnt"},   32'(a_cnt),   cnt);
  endtask

  task automatic check_b(input string tag, input int cur, input int over,
                         input int lsr, input int cause, input int cnt);
    chk({tag, ".b_cur"},   32'(b_cur),   cur);
    chk({tag, ".b_over"},  32'(b_over),  over);
    chk({tag, ".b_loser"}, 32'(b_loser), lsr);
    chk({tag, ".b_cause"}, 32'(b_cause), cause);
    chk({tag, ".b_cnt"},   32'(b_cnt),   cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    btn6 = '0; mv6 = '0; btn2 = '0; mv2 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_mv6(input int p, input int mv);
    logic [2:0] m;
    m = mv[2:0];
    mv6[3*p-1 -: 3] = m;
  endtask

  // Raise player p's button with move mv; returns #1 after the update edge.
  task automatic press6(input int p, input int mv);
    @(negedge clk);
    set_mv6(p, mv);
    btn6[p-1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic press2(input int p, input int mv);
    logic [2:0] m;
    m = mv[2:0];
    @(negedge clk);
    mv2[3*p-1 -: 3] = m;
    btn2[p-1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    btn6 = '0;
    btn2 = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_cur;
    tbl[0]  = '{1, 4, 2, 0, 0, 0, 1};
    tbl[1]  = '{2, 1, 6, 0, 0, 0, 2};
    tbl[2]  = '{6, 5, 2, 0, 0, 0, 3};
    tbl[3]  = '{2, 2, 1, 0, 0, 0, 4};
    tbl[4]  = '{1, 2, 6, 0, 0, 0, 5};
    tbl[5]  = '{6, 4, 1, 0, 0, 0, 6};
    tbl[6]  = '{1, 5, 3, 0, 0, 0, 7};
    tbl[7]  = '{3, 7, 3, 1, 3, 1, 7};
    tbl[8]  = '{1, 4, 3, 1, 3, 1, 7};
    tbl[9]  = '{3, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 1, 1, 1, 0};
    tbl[11] = '{1, 4, 1, 0, 0, 0, 0};
    tbl[12] = '{1, 4, 2, 0, 0, 0, 1};
    tbl[13] = '{4, 4, 4, 1, 4, 2, 1};
    tbl[14] = '{4, 3, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 6, 1, 1, 1, 1, 0};

    // Reset values
    do_reset();
    check_a("reset", 1, 0, 0, 0, 0);
    chk("reset.c_cur", 32'(c_cur), 1);
    chk("reset.c_over", 32'(c_over), 0);

    // Vector table on the default instance, with a latency check per press
    prev_cur = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_mv6(tbl[i].p, tbl[i].mv);
      btn6[tbl[i].p-1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d.latency", i), 32'(a_cur), prev_cur);
      @(posedge clk);
      #1;
      check_a($sformatf("v%0d", i), tbl[i].cur, tbl[i].over, tbl[i].loser,
              tbl[i].cause, tbl[i].cnt);
      release_all();
      prev_cur = tbl[i].cur;
    end

    // Simultaneous presses 2,4,5 with player 2 current
    do_reset();
    press6(1, 4);
    chk("sim.pre_a_cur", 32'(a_cur), 2);
    chk("sim.pre_b_cur", 32'(b_cur), 2);
    release_all();
    @(negedge clk);
    set_mv6(2, 4);
    btn6 = 6'b011010;
    repeat (3) @(posedge clk);
    #1;
    check_a("wrong", 4, 1, 4, 2, 1);
    check_b("nowrong", 3, 0, 0, 0, 2);
    btn6 = '0;

    // Timeout: loss exactly 10 cycles after player 3's turn began
    repeat (9) @(posedge clk);
    #1;
    chk("tmo.early_over", 32'(b_over), 0);
    @(posedge clk);
    #1;
    check_b("tmo", 3, 1, 3, 3, 2);

    // Loser restart with START_WITH_LOSER=1; default instance ignores non-loser
    press6(3, 0);
    check_b("restart_b", 3, 0, 0, 0, 0);
    check_a("ignore_a", 4, 1, 4, 2, 1);

    // Press lands on the same edge as the timeout: move wins
    btn6 = '0;
    repeat (7) @(posedge clk);
    #1;
    set_mv6(3, 4);
    btn6[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("race.pre_cur", 32'(b_cur), 3);
    chk("race.pre_over", 32'(b_over), 0);
    @(posedge clk);
    #1;
    check_b("race", 4, 0, 0, 0, 1);
    release_all();

    // Two-player wrap
    do_reset();
    press2(1, 5);
    chk("n2.fwd2_cur", 32'(c_cur), 1);
    chk("n2.fwd2_cnt", 32'(c_cnt), 1);
    release_all();
    press2(1, 1);
    chk("n2.back2_cur", 32'(c_cur), 1);
    chk("n2.back2_cnt", 32'(c_cnt), 2);
    release_all();
    press2(1, 4);
    chk("n2.fwd1_cur", 32'(c_cur), 2);
    release_all();
    press2(2, 2);
    chk("n2.back1_cur", 32'(c_cur), 1);
    chk("n2.back1_over", 32'(c_over), 0);
    release_all();

    // Async reset mid-LOSS while player 1's button is held
    do_reset();
    press6(1, 7);
    check_a("preloss", 1, 1, 1, 1, 0);
    release_all();
    @(negedge clk);
    set_mv6(1, 4);
    btn6[0] = 1'b1;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_a("async_rst", 1, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("held.cur", 32'(a_cur), 1);
    chk("held.cnt", 32'(a_cnt), 0);
    release_all();
    press6(1, 4);
    chk("repress.cur", 32'(a_cur), 2);
    chk("repress.cnt", 32'(a_cnt), 1);
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
